// File: rtl/i2c_mcp23017_target.sv
// I2C target emulating the MCP23017 register subset (IODIR, GPIO, OLAT).
// Oversamples SCL/SDA on clk, decodes START/STOP and bytes, ACKs the
// matching address, and supports pointer auto-increment for writes and reads.
`timescale 1ns/1ps

module i2c_mcp23017_target #(
    parameter logic [2:0] HW_ADDRESS = 3'b100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [7:0] gpio_a_in,
    input  logic [7:0] gpio_b_in,
    output logic [7:0] iodir_a,
    output logic [7:0] iodir_b,
    output logic [7:0] olat_a,
    output logic [7:0] olat_b,
    output logic       reg_wr
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK,
        WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    // Bit 0 is SCL, bit 1 is SDA for the conditioning pipelines.
    logic [1:0] pad_in;
    logic [1:0] sync_s;
    logic [1:0] hist_s;

    assign pad_in = {sda_in, scl_in};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic [2:0] pipe_reg;
            // Two synchronizer flops followed by one history flop; idle bus is high.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    pipe_reg <= 3'b111;
                end else begin
                    pipe_reg <= {pipe_reg[1:0], pad_in[gi]};
                end
            end
            assign sync_s[gi] = pipe_reg[1];
            assign hist_s[gi] = pipe_reg[2];
        end
    endgenerate

    logic scl_s, scl_h, sda_s, sda_h;
    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_s     = sync_s[0];
    assign scl_h     = hist_s[0];
    assign sda_s     = sync_s[1];
    assign sda_h     = hist_s[1];
    assign scl_rise  = scl_s & ~scl_h;
    assign scl_fall  = ~scl_s & scl_h;
    assign start_det = scl_s & scl_h & sda_h & ~sda_s;
    assign stop_det  = scl_s & scl_h & ~sda_h & sda_s;

    state_t     state_reg;
    logic [2:0] bit_cnt_reg;
    logic [7:0] shift_reg;
    logic [7:0] rd_shift_reg;
    logic [7:0] ptr_reg;
    logic       rw_reg;
    logic       ack_phase_reg;
    logic       sda_oe_reg;
    logic       reg_wr_reg;
    logic [7:0] iodir_a_reg, iodir_b_reg, olat_a_reg, olat_b_reg;

    logic [7:0] rx_byte;
    logic [7:0] ptr_inc;

    assign rx_byte = {shift_reg[6:0], sda_s};
    // The register file ends at 0x15; out-of-map pointers just count up and wrap at 0xFF.
    assign ptr_inc = (ptr_reg == 8'h15) ? 8'h00 : ptr_reg + 8'd1;

    assign sda_oe  = sda_oe_reg;
    assign reg_wr  = reg_wr_reg;
    assign iodir_a = iodir_a_reg;
    assign iodir_b = iodir_b_reg;
    assign olat_a  = olat_a_reg;
    assign olat_b  = olat_b_reg;

    // Read view of the register map; GPIO reads return live pin levels.
    function automatic logic [7:0] reg_value(input logic [7:0] addr);
        case (addr)
            8'h00:   return iodir_a_reg;
            8'h01:   return iodir_b_reg;
            8'h12:   return gpio_a_in;
            8'h13:   return gpio_b_in;
            8'h14:   return olat_a_reg;
            8'h15:   return olat_b_reg;
            default: return 8'h00;
        endcase
    endfunction

    // Protocol FSM, register file and open-drain SDA driver.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= 3'd0;
            shift_reg     <= 8'h00;
            rd_shift_reg  <= 8'h00;
            ptr_reg       <= 8'h00;
            rw_reg        <= 1'b0;
            ack_phase_reg <= 1'b0;
            sda_oe_reg    <= 1'b0;
            reg_wr_reg    <= 1'b0;
            iodir_a_reg   <= 8'hFF;
            iodir_b_reg   <= 8'hFF;
            olat_a_reg    <= 8'h00;
            olat_b_reg    <= 8'h00;
        end else begin
            reg_wr_reg <= 1'b0;
            if (start_det) begin
                // Also covers repeated START; any partial byte is dropped.
                state_reg     <= ADDR;
                bit_cnt_reg   <= 3'd0;
                ack_phase_reg <= 1'b0;
                sda_oe_reg    <= 1'b0;
            end else if (stop_det) begin
                state_reg     <= IDLE;
                bit_cnt_reg   <= 3'd0;
                ack_phase_reg <= 1'b0;
                sda_oe_reg    <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE, IGNORE: begin
                    end
                    ADDR: begin
                        if (scl_rise) begin
                            shift_reg <= rx_byte;
                            if (bit_cnt_reg == 3'd7) begin
                                bit_cnt_reg <= 3'd0;
                                if (rx_byte[7:1] == {4'b0100, HW_ADDRESS}) begin
                                    rw_reg    <= rx_byte[0];
                                    state_reg <= ADDR_ACK;
                                end else begin
                                    state_reg <= IGNORE;
                                end
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_rise && rw_reg) begin
                            // Preload on the ACK clock so the first bit is ready at the next fall.
                            rd_shift_reg <= reg_value(ptr_reg);
                        end else if (scl_fall) begin
                            if (!ack_phase_reg) begin
                                sda_oe_reg    <= 1'b1;
                                ack_phase_reg <= 1'b1;
                            end else begin
                                ack_phase_reg <= 1'b0;
                                if (rw_reg) begin
                                    state_reg    <= RDATA;
                                    sda_oe_reg   <= ~rd_shift_reg[7];
                                    rd_shift_reg <= {rd_shift_reg[6:0], 1'b0};
                                end else begin
                                    state_reg  <= REG;
                                    sda_oe_reg <= 1'b0;
                                end
                            end
                        end
                    end
                    REG: begin
                        if (scl_rise) begin
                            shift_reg <= rx_byte;
                            if (bit_cnt_reg == 3'd7) begin
                                bit_cnt_reg <= 3'd0;
                                ptr_reg     <= rx_byte;
                                state_reg   <= REG_ACK;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            end
                        end
                    end
                    REG_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase_reg) begin
                                sda_oe_reg    <= 1'b1;
                                ack_phase_reg <= 1'b1;
                            end else begin
                                sda_oe_reg    <= 1'b0;
                                ack_phase_reg <= 1'b0;
                                state_reg     <= WDATA;
                            end
                        end
                    end
                    WDATA: begin
                        if (scl_rise) begin
                            shift_reg <= rx_byte;
                            if (bit_cnt_reg == 3'd7) begin
                                bit_cnt_reg <= 3'd0;
                                state_reg   <= WDATA_ACK;
                                ptr_reg     <= ptr_inc;
                                // GPIO writes land in the output latches, as on the real part.
                                case (ptr_reg)
                                    8'h00: begin iodir_a_reg <= rx_byte; reg_wr_reg <= 1'b1; end
                                    8'h01: begin iodir_b_reg <= rx_byte; reg_wr_reg <= 1'b1; end
                                    8'h12, 8'h14: begin olat_a_reg <= rx_byte; reg_wr_reg <= 1'b1; end
                                    8'h13, 8'h15: begin olat_b_reg <= rx_byte; reg_wr_reg <= 1'b1; end
                                    default: begin end
                                endcase
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            end
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            if (bit_cnt_reg == 3'd7) begin
                                bit_cnt_reg <= 3'd0;
                                state_reg   <= RDATA_ACK;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            end
                        end else if (scl_fall) begin
                            sda_oe_reg   <= ~rd_shift_reg[7];
                            rd_shift_reg <= {rd_shift_reg[6:0], 1'b0};
                        end
                    end
                    RDATA_ACK: begin
                        if (scl_rise) begin
                            if (sda_s) begin
                                // Master NACK ends the read burst.
                                state_reg     <= IGNORE;
                                ack_phase_reg <= 1'b0;
                            end else begin
                                ptr_reg      <= ptr_inc;
                                rd_shift_reg <= reg_value(ptr_inc);
                            end
                        end else if (scl_fall) begin
                            if (!ack_phase_reg) begin
                                // Release the bus so the master can drive its ACK bit.
                                sda_oe_reg    <= 1'b0;
                                ack_phase_reg <= 1'b1;
                            end else begin
                                ack_phase_reg <= 1'b0;
                                state_reg     <= RDATA;
                                sda_oe_reg    <= ~rd_shift_reg[7];
                                rd_shift_reg  <= {rd_shift_reg[6:0], 1'b0};
                            end
                        end
                    end
                    default: begin
                        state_reg  <= IDLE;
                        sda_oe_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_mcp23017_target.sv
// Bench for i2c_mcp23017_target: a bit-banged I2C master at 100 kHz drives
// directed transactions; expected ACK/data bits and register snapshots are
// queued at stimulus time and a monitor compares them as the DUT responds.
`timescale 1ns/1ps

module tb_i2c_mcp23017_target;

    localparam int Q           = 2500;   // quarter SCL period at 100 kHz
    localparam int WR_TOTAL    = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] gpio_a_in = 8'h5A;
    logic [7:0] gpio_b_in = 8'hA3;
    logic [7:0] iodir_a, iodir_b, olat_a, olat_b;
    logic       reg_wr;

    assign sda_line = sda_m & ~sda_oe;

    always #42 clk = ~clk;

    i2c_mcp23017_target #(.HW_ADDRESS(3'b100)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (scl_m),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .gpio_a_in (gpio_a_in),
        .gpio_b_in (gpio_b_in),
        .iodir_a   (iodir_a),
        .iodir_b   (iodir_b),
        .olat_a    (olat_a),
        .olat_b    (olat_b),
        .reg_wr    (reg_wr)
    );

    typedef struct {
        string       name;
        logic [31:0] val;
    } item_t;

    item_t       exp_q[$];
    item_t       obs_q[$];
    logic [31:0] wr_exp_q[$];

    int n_cmp  = 0;
    int n_bad  = 0;
    int wr_cnt = 0;
    int oe_cnt = 0;
    bit quiet_watch = 1'b0;
    bit done = 1'b0;

    task automatic push_exp(input string n, input logic [31:0] v);
        item_t it;
        it.name = n;
        it.val  = v;
        exp_q.push_back(it);
    endtask

    task automatic push_obs(input string n, input logic [31:0] v);
        item_t it;
        it.name = n;
        it.val  = v;
        obs_q.push_back(it);
    endtask

    task automatic direct(input string n, input logic [31:0] act, input logic [31:0] e);
        push_exp(n, e);
        push_obs(n, act);
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #Q;
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; #Q;
        scl_m = 1'b1; #(2*Q);
        scl_m = 1'b0; #Q;
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        b = sda_line; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic send_byte(input logic [7:0] d, input string n, input logic exp_ack);
        logic a;
        push_exp(n, {31'd0, exp_ack});
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(a);
        push_obs(n, {31'd0, a});
    endtask

    task automatic recv_byte(input logic [7:0] e, input string n, input logic master_ack);
        logic [7:0] d;
        logic       b;
        push_exp(n, {24'd0, e});
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        push_obs(n, {24'd0, d});
        send_bit(master_ack);
    endtask

    // Monitor: every comparison and both counters live here.
    initial begin
        item_t       o;
        item_t       e;
        logic [31:0] ew;
        forever begin
            @(negedge clk);
            if (quiet_watch) begin
                if (sda_oe) oe_cnt++;
            end else begin
                oe_cnt = 0;
            end
            if (reg_wr) begin
                wr_cnt++;
                n_cmp++;
                if (wr_exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL reg_wr_unexpected: got write with regs %08h, required no write",
                             {iodir_a, iodir_b, olat_a, olat_b});
                end else begin
                    ew = wr_exp_q.pop_front();
                    if ({iodir_a, iodir_b, olat_a, olat_b} !== ew) begin
                        n_bad++;
                        $display("FAIL reg_wr_regs: got %08h, required %08h",
                                 {iodir_a, iodir_b, olat_a, olat_b}, ew);
                    end
                end
            end
            if (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL %s: got %0h, required no observation", o.name, o.val);
                end else begin
                    e = exp_q.pop_front();
                    if (o.val !== e.val) begin
                        n_bad++;
                        $display("FAIL %s: got %0h, required %0h", o.name, o.val, e.val);
                    end
                end
            end
            if (done) begin
                n_cmp++;
                if (wr_cnt != WR_TOTAL) begin
                    n_bad++;
                    $display("FAIL reg_wr_count: got %0d, required %0d", wr_cnt, WR_TOTAL);
                end
                n_cmp++;
                if (exp_q.size() != 0 || wr_exp_q.size() != 0 || obs_q.size() != 0) begin
                    n_bad++;
                    $display("FAIL scoreboard_drain: got %0d/%0d/%0d left, required 0/0/0",
                             exp_q.size(), wr_exp_q.size(), obs_q.size());
                end
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
        end
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "bench timeout");
    end

    // Directed stimulus.
    initial begin
        logic [3:0] half = 4'b1010;

        // Reset
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        direct("reset_iodir_a", {24'd0, iodir_a}, 32'h0000_00FF);
        direct("reset_iodir_b", {24'd0, iodir_b}, 32'h0000_00FF);
        direct("reset_olat_a",  {24'd0, olat_a},  32'h0000_0000);
        direct("reset_olat_b",  {24'd0, olat_b},  32'h0000_0000);
        direct("reset_sda_oe",  {31'd0, sda_oe},  32'h0000_0000);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);

        // Read GPIOB then OLATA through a repeated START
        i2c_start;
        send_byte(8'h48, "rd_addr_w_ack", 1'b0);
        send_byte(8'h13, "rd_ptr_ack", 1'b0);
        i2c_start;
        send_byte(8'h49, "rd_addr_r_ack", 1'b0);
        recv_byte(8'hA3, "rd_gpiob", 1'b0);
        recv_byte(8'h00, "rd_olata", 1'b1);
        i2c_stop;

        // Single write to GPIOA lands in OLATA
        wr_exp_q.push_back(32'hFFFF_5500);
        i2c_start;
        send_byte(8'h48, "w1_addr_ack", 1'b0);
        send_byte(8'h12, "w1_ptr_ack", 1'b0);
        send_byte(8'h55, "w1_data_ack", 1'b0);
        i2c_stop;

        // Sequential write IODIRA, IODIRB
        wr_exp_q.push_back(32'h0FFF_5500);
        wr_exp_q.push_back(32'h0FF0_5500);
        i2c_start;
        send_byte(8'h48, "w2_addr_ack", 1'b0);
        send_byte(8'h00, "w2_ptr_ack", 1'b0);
        send_byte(8'h0F, "w2_d0_ack", 1'b0);
        send_byte(8'hF0, "w2_d1_ack", 1'b0);
        i2c_stop;

        // Unmapped register: ACKed, discarded, no reg_wr
        i2c_start;
        send_byte(8'h48, "w3_addr_ack", 1'b0);
        send_byte(8'h05, "w3_ptr_ack", 1'b0);
        send_byte(8'h99, "w3_data_ack", 1'b0);
        i2c_stop;
        #1;
        direct("w3_regs_kept", {iodir_a, iodir_b, olat_a, olat_b}, 32'h0FF0_5500);

        // Address mismatch: no ACK and SDA never pulled
        quiet_watch = 1'b1;
        i2c_start;
        send_byte(8'h4A, "mm_addr_nack", 1'b1);
        send_byte(8'h12, "mm_ptr_nack", 1'b1);
        send_byte(8'h77, "mm_data_nack", 1'b1);
        i2c_stop;
        @(posedge clk); #1;
        direct("mm_sda_oe_quiet", oe_cnt, 32'd0);
        quiet_watch = 1'b0;
        direct("mm_olat_a", {24'd0, olat_a}, 32'h0000_0055);

        // Pointer wrap 0x15 -> 0x00
        wr_exp_q.push_back(32'h0FF0_5501);
        wr_exp_q.push_back(32'h02F0_5501);
        i2c_start;
        send_byte(8'h48, "wrap_addr_ack", 1'b0);
        send_byte(8'h15, "wrap_ptr_ack", 1'b0);
        send_byte(8'h01, "wrap_d0_ack", 1'b0);
        send_byte(8'h02, "wrap_d1_ack", 1'b0);
        i2c_stop;

        // STOP after four data bits: partial byte dropped
        i2c_start;
        send_byte(8'h48, "abort_addr_ack", 1'b0);
        send_byte(8'h14, "abort_ptr_ack", 1'b0);
        for (int i = 3; i >= 0; i--) send_bit(half[i]);
        i2c_stop;
        repeat (10) @(posedge clk);
        #1;
        direct("abort_regs_kept", {iodir_a, iodir_b, olat_a, olat_b}, 32'h02F0_5501);
        direct("abort_sda_oe", {31'd0, sda_oe}, 32'd0);

        // Next transaction behaves normally after the abort
        wr_exp_q.push_back(32'h02F0_3C01);
        i2c_start;
        send_byte(8'h48, "post_addr_ack", 1'b0);
        send_byte(8'h14, "post_ptr_ack", 1'b0);
        send_byte(8'h3C, "post_data_ack", 1'b0);
        i2c_stop;

        repeat (20) @(posedge clk);
        done = 1'b1;
    end

endmodule
